// File: rtl/rst_seq_pkg.sv
// Shared types, parameter limits and counter sizing for the reset sequencer.
// Imported by rst_seq and sync_ff.
package rst_seq_pkg;

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_RUN     = 2'd3
   } state_t;

   localparam int NUM_CH_MIN = 1;
   localparam int NUM_CH_MAX = 16;
   localparam int HOLD_MIN   = 1;
   localparam int HOLD_MAX   = 255;
   localparam int GAP_MIN    = 1;
   localparam int GAP_MAX    = 255;
   localparam int SYNC_MIN   = 2;
   localparam int SYNC_MAX   = 4;
   localparam int WDT_MIN    = 2;
   localparam int WDT_MAX    = 65535;

   // One spare bit above the largest count so no counter can ever wrap.
   function automatic int cnt_width(input int hold, input int gap, input int wdt);
      int m;
      m = hold;
      if (gap > m) m = gap;
      if (wdt > m) m = wdt;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/rst_seq_sync_ff.sv
// Multi-flop level synchroniser for an asynchronous input; DEPTH cycles of latency.
// Cleared to 0 by the synchronous reset.
module sync_ff
   import rst_seq_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] sync_q;
   logic [DEPTH-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[DEPTH-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/rst_seq.sv
// Power-on reset sequencer: hold all domains, then release them in index order.
// Optional watchdog compiled in with RST_SEQ_WDT_EN.
module rst_seq
   import rst_seq_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int HOLD        = 5,
   parameter int GAP         = 2,
   parameter int SYNC_STAGES = 2,
   parameter int WDT_CYCLES  = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pwrOn,
   input  logic              swRst,
`ifdef RST_SEQ_WDT_EN
   input  logic              wdtKick,
   output logic              wdtBite,
`endif
   output logic [NUM_CH-1:0] rstn,
   output logic              done
);

   localparam int CW = cnt_width(HOLD, GAP, WDT_CYCLES);
   localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [CW-1:0] HOLD_FULL = CW'(HOLD);
   localparam logic [CW-1:0] HOLD_PWR  = CW'(HOLD - 1);
   localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

   if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
      $error("rst_seq: NUM_CH out of range");
   end
   if (HOLD < HOLD_MIN || HOLD > HOLD_MAX) begin : g_bad_hold
      $error("rst_seq: HOLD out of range");
   end
   if (GAP < GAP_MIN || GAP > GAP_MAX) begin : g_bad_gap
      $error("rst_seq: GAP out of range");
   end
   if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("rst_seq: SYNC_STAGES out of range");
   end
   if (WDT_CYCLES < WDT_MIN || WDT_CYCLES > WDT_MAX) begin : g_bad_wdt
      $error("rst_seq: WDT_CYCLES out of range");
   end

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NUM_CH-1:0] rstn_q, rstn_d;
   logic              done_q, done_d;
   logic              pwr_sync;
   logic              fire;
   logic              sw_req;

   sync_ff #(.DEPTH(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (pwrOn),
      .q   (pwr_sync)
   );

`ifdef RST_SEQ_WDT_EN
   localparam logic [CW-1:0] WDT_PRE = CW'(WDT_CYCLES - 2);
   localparam logic [CW-1:0] WDT_TOP = CW'(WDT_CYCLES - 1);

   logic [CW-1:0] wdt_q, wdt_d;
   logic          bite_q, bite_d;

   // A bite restarts the sequence exactly like a software reset.
   assign sw_req = (state_q == ST_RUN) && (swRst || bite_q);

   always_comb begin
      wdt_d  = '0;
      bite_d = 1'b0;
      if (pwr_sync && state_q == ST_RUN && !sw_req && !wdtKick) begin
         bite_d = (wdt_q == WDT_PRE);
         wdt_d  = (wdt_q == WDT_TOP) ? wdt_q : wdt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wdt_q  <= '0;
         bite_q <= 1'b0;
      end else begin
         wdt_q  <= wdt_d;
         bite_q <= bite_d;
      end
   end

   assign wdtBite = bite_q;
`else
   assign sw_req = (state_q == ST_RUN) && swRst;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         cnt_q   <= '0;
         idx_q   <= '0;
         rstn_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         rstn_q  <= rstn_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      fire    = 1'b0;
      if (!pwr_sync) begin
         state_d = ST_OFF;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            // The edge that first sees power good already counts as a hold cycle.
            ST_OFF: begin
               idx_d = '0;
               if (HOLD <= 1) begin
                  fire = 1'b1;
               end else begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_PWR;
               end
            end
            ST_HOLD, ST_RELEASE: begin
               if (cnt_q <= CNT_ONE) fire = 1'b1;
               else                  cnt_d = cnt_q - 1'b1;
            end
            ST_RUN: begin
               if (sw_req) begin
                  state_d = ST_HOLD;
                  cnt_d   = HOLD_FULL;
                  idx_d   = '0;
               end
            end
            default: state_d = ST_OFF;
         endcase
         if (fire) begin
            if (idx_q == IDX_LAST) begin
               state_d = ST_RUN;
               cnt_d   = '0;
            end else begin
               state_d = ST_RELEASE;
               cnt_d   = GAP_LOAD;
               idx_d   = idx_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rstn_d = rstn_q;
      done_d = (state_d == ST_RUN);
      if (state_d == ST_OFF || state_d == ST_HOLD) begin
         rstn_d = '0;
      end else if (fire) begin
         rstn_d = rstn_q | (NUM_CH'(1) << idx_q);
      end
   end

   assign rstn = rstn_q;
   assign done = done_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: expected samples are queued per scenario and compared as edges pass.
// Exercises the watchdog only when RST_SEQ_WDT_EN is defined.
module tb_rst_seq;

   typedef struct {
      int         edge_n;
      int         who;
      logic [3:0] r;
      logic       f;
   } chk_t;

   logic       clk = 1'b0;
   logic       rst, pwrOn, swRst, sw1;
   logic [3:0] rstn;
   logic       done;
   logic [0:0] rstn1;
   logic       done1;
`ifdef RST_SEQ_WDT_EN
   logic       kick, bite_main, bite1, bite_w, done_w;
   logic [3:0] rstn_w;
`endif

   chk_t sb[$];
   chk_t tbl_a [18];
   chk_t tbl_b [9];
   chk_t tbl_c [6];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ecnt    = 0;

   always #5 clk = ~clk;

   rst_seq dut (
      .clk(clk), .rst(rst), .pwrOn(pwrOn), .swRst(swRst),
`ifdef RST_SEQ_WDT_EN
      .wdtKick(1'b0), .wdtBite(bite_main),
`endif
      .rstn(rstn), .done(done)
   );

   rst_seq #(.NUM_CH(1), .HOLD(1), .GAP(1)) dut1 (
      .clk(clk), .rst(rst), .pwrOn(pwrOn), .swRst(sw1),
`ifdef RST_SEQ_WDT_EN
      .wdtKick(1'b0), .wdtBite(bite1),
`endif
      .rstn(rstn1), .done(done1)
   );

`ifdef RST_SEQ_WDT_EN
   rst_seq #(.WDT_CYCLES(8)) dut_w (
      .clk(clk), .rst(rst), .pwrOn(pwrOn), .swRst(1'b0),
      .wdtKick(kick), .wdtBite(bite_w),
      .rstn(rstn_w), .done(done_w)
   );
`endif

   task automatic check(input string name, input logic [3:0] ar, input logic af,
                        input logic [3:0] er, input logic ef);
      n_tests++;
      if (ar !== er || af !== ef) begin
         n_fail++;
         $display("FAIL %s: got rstn=%b flag=%b, expected rstn=%b flag=%b", name, ar, af, er, ef);
      end
   endtask

   function automatic void sb_push(input int e, input int who, input logic [3:0] r, input logic f);
      chk_t c;
      int   i;
      c.edge_n = e; c.who = who; c.r = r; c.f = f;
      i = 0;
      while (i < sb.size() && sb[i].edge_n <= e) i++;
      sb.insert(i, c);
   endfunction

   task automatic step();
      chk_t       c;
      logic [3:0] ar;
      logic       af;
      @(posedge clk);
      #1;
      ecnt++;
      while (sb.size() > 0 && sb[0].edge_n <= ecnt) begin
         c = sb.pop_front();
         case (c.who)
            0:       begin ar = rstn; af = done; end
            1:       begin ar = {3'b000, rstn1}; af = done1; end
`ifdef RST_SEQ_WDT_EN
            default: begin ar = rstn_w; af = bite_w; end
`else
            default: begin ar = 4'bxxxx; af = 1'bx; end
`endif
         endcase
         check($sformatf("dut%0d@edge%0d", c.who, c.edge_n), ar, af, c.r, c.f);
      end
   endtask

   task automatic scn_start();
      rst = 1'b1; pwrOn = 1'b1; swRst = 1'b0; sw1 = 1'b0;
`ifdef RST_SEQ_WDT_EN
      kick = 1'b0;
`endif
      repeat (3) step();
      check("reset_main", rstn, done, 4'b0000, 1'b0);
      check("reset_ch1", {3'b000, rstn1}, done1, 4'b0000, 1'b0);
      pwrOn = 1'b0; rst = 1'b0;
      repeat (2) step();
      pwrOn = 1'b1;
      ecnt = 0;
   endtask

   task automatic scn_end(input string name);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL %s_leftover: got %0d unchecked samples, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   initial begin
      tbl_a = '{
         '{6, 0, 4'b0000, 1'b0}, '{7, 0, 4'b0001, 1'b0}, '{8, 0, 4'b0001, 1'b0},
         '{9, 0, 4'b0011, 1'b0}, '{10, 0, 4'b0011, 1'b0}, '{11, 0, 4'b0111, 1'b0},
         '{12, 0, 4'b0111, 1'b0}, '{13, 0, 4'b1111, 1'b1}, '{20, 0, 4'b1111, 1'b1},
         '{21, 0, 4'b0000, 1'b0}, '{25, 0, 4'b0000, 1'b0}, '{26, 0, 4'b0001, 1'b0},
         '{28, 0, 4'b0011, 1'b0}, '{31, 0, 4'b0111, 1'b0}, '{32, 0, 4'b1111, 1'b1},
         '{2, 1, 4'b0000, 1'b0}, '{3, 1, 4'b0001, 1'b1}, '{10, 1, 4'b0001, 1'b1}
      };
      tbl_b = '{
         '{9, 0, 4'b0011, 1'b0}, '{10, 0, 4'b0011, 1'b0}, '{11, 0, 4'b0111, 1'b0},
         '{12, 0, 4'b0000, 1'b0}, '{16, 0, 4'b0000, 1'b0}, '{29, 0, 4'b1111, 1'b1},
         '{37, 0, 4'b0000, 1'b0}, '{42, 0, 4'b0001, 1'b0}, '{48, 0, 4'b1111, 1'b1}
      };
      tbl_c = '{
         '{9, 0, 4'b0011, 1'b0}, '{10, 0, 4'b0000, 1'b0}, '{11, 0, 4'b0000, 1'b0},
         '{17, 0, 4'b0000, 1'b0}, '{18, 0, 4'b0001, 1'b0}, '{24, 0, 4'b1111, 1'b1}
      };

      // Power-up sequence, swRst ignored in HOLD/RELEASE, swRst restart from RUN.
      scn_start();
      for (int i = 0; i < 18; i++) sb_push(tbl_a[i].edge_n, tbl_a[i].who, tbl_a[i].r, tbl_a[i].f);
`ifdef RST_SEQ_WDT_EN
      sb_push(13, 2, 4'b1111, 1'b0);
      sb_push(19, 2, 4'b1111, 1'b0);
      sb_push(20, 2, 4'b1111, 1'b1);
      sb_push(21, 2, 4'b0000, 1'b0);
`endif
      for (int e = 0; e < 34; e++) begin
         swRst = (ecnt == 4 || ecnt == 8 || ecnt == 20);
         step();
      end
      swRst = 1'b0;
      sw1 = 1'b1;
      step();
      check("ch1_swrst_clear", {3'b000, rstn1}, done1, 4'b0000, 1'b0);
      sw1 = 1'b0;
      step();
      check("ch1_swrst_release", {3'b000, rstn1}, done1, 4'b0001, 1'b1);
      check("main_stays_run", rstn, done, 4'b1111, 1'b1);
      scn_end("power_up");

      // Power loss mid-release, recovery, then a one-cycle dip coinciding with swRst.
      scn_start();
      for (int i = 0; i < 9; i++) sb_push(tbl_b[i].edge_n, tbl_b[i].who, tbl_b[i].r, tbl_b[i].f);
      for (int e = 0; e < 48; e++) begin
         pwrOn = !((ecnt >= 9 && ecnt < 16) || ecnt == 34);
         swRst = (ecnt == 36);
         step();
      end
      swRst = 1'b0;
      pwrOn = 1'b1;
      scn_end("power_loss");

      // Synchronous reset in the middle of a sequence; watchdog kept alive by kicks.
      scn_start();
      for (int i = 0; i < 6; i++) sb_push(tbl_c[i].edge_n, tbl_c[i].who, tbl_c[i].r, tbl_c[i].f);
`ifdef RST_SEQ_WDT_EN
      for (int e = 25; e <= 60; e++) sb_push(e, 2, 4'b1111, 1'b0);
`endif
      for (int e = 0; e < 60; e++) begin
         rst = (ecnt >= 9 && ecnt < 11);
`ifdef RST_SEQ_WDT_EN
         kick = (ecnt % 4 == 0);
`endif
         step();
      end
      rst = 1'b0;
      scn_end("mid_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
